// File: rtl/lcg_rng_checker.sv
// lcg_rng_checker: tracks a 16-bit LCG stream, x' = (MULT*x + INC) mod 2^16.
// The first accepted sample seeds the predictor. Every later sample is compared
// with the prediction. After LOCK_COUNT consecutive matches the checker reports
// lock. A mismatch is counted and strobed on err_pulse.
// All outputs are registered, so they reflect the sample accepted on the previous edge.
//
// Optional feature: define LCG_CHK_RESYNC_EN to resynchronise on a mismatch
// instead of entering the sticky FAIL state. With the macro defined, fail stays 0.

module lcg_rng_checker #(
    parameter int unsigned MULT       = 25173,
    parameter int unsigned INC        = 13849,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        clear,
    output logic        locked,
    output logic        fail,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] sample_count,
    output logic [15:0] expected
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StTrack = 2'd1;
    localparam logic [1:0] StFail  = 2'd2;

    localparam logic [7:0]  LockMax = 8'(LOCK_COUNT);
    localparam logic [31:0] MultW   = 32'(MULT);
    localparam logic [31:0] IncW    = 32'(INC);

    logic [1:0]  state_q, state_d;
    logic [15:0] exp_q, exp_d;
    logic [7:0]  run_q, run_d;
    logic        locked_q, locked_d;
    logic        fail_q, fail_d;
    logic        err_pulse_q, err_pulse_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] samp_q, samp_d;
    logic [15:0] next_val;

    // Predicted successor of the incoming sample; only the low 16 bits matter.
    function automatic logic [15:0] lcg_next(input logic [15:0] x);
        logic [31:0] p;
        p = MultW * {16'd0, x} + IncW;
        return p[15:0];
    endfunction

    // Successor of the current sample, shared by the seed, match and resync paths.
    always_comb begin
        next_val = lcg_next(in_data);
    end

    // Next-state and output computation for one accepted sample.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        run_d       = run_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        samp_d      = samp_q;
        if (clear) begin
            // Clear has priority over a coincident sample, which is dropped.
            state_d   = StIdle;
            exp_d     = 16'd0;
            run_d     = 8'd0;
            err_cnt_d = 16'd0;
            samp_d    = 32'd0;
        end else if (in_valid) begin
            samp_d = samp_q + 32'd1;
            case (state_q)
                StIdle: begin
                    exp_d   = next_val;
                    run_d   = 8'd0;
                    state_d = StTrack;
                end
                StTrack: begin
                    if (in_data == exp_q) begin
                        exp_d = next_val;
                        run_d = (run_q >= LockMax) ? LockMax : run_q + 8'd1;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
`ifdef LCG_CHK_RESYNC_EN
                        // Restart prediction from the offending sample.
                        exp_d = next_val;
                        run_d = 8'd0;
`else
                        state_d = StFail;
`endif
                    end
                end
                StFail: begin
                    // Samples are counted only; the prediction is frozen.
                end
                default: state_d = StIdle;
            endcase
        end
        locked_d = (state_d == StTrack) && (run_d == LockMax);
        fail_d   = (state_d == StFail);
    end

    // State and registered outputs; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            exp_q       <= 16'd0;
            run_q       <= 8'd0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= 16'd0;
            samp_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            run_q       <= run_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            samp_q      <= samp_d;
        end
    end

    assign locked       = locked_q;
    assign fail         = fail_q;
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_cnt_q;
    assign sample_count = samp_q;
    assign expected     = exp_q;

endmodule

// File: tb/tb_lcg_rng_checker.sv
// Directed bench for lcg_rng_checker (default parameters).
// Expected LCG values were worked out by hand:
//   1 -> 39022 -> 61087 -> 20196 -> 45005 -> 3882
//   39023 -> 20724 -> 32541 -> 33978 -> 31707 -> 11216
//   5 -> 8642

module tb_lcg_rng_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        clear = 1'b0;
    logic        locked;
    logic        fail;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] sample_count;
    logic [15:0] expected;

    int checks = 0;
    int errors = 0;

    lcg_rng_checker dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .clear        (clear),
        .locked       (locked),
        .fail         (fail),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .sample_count (sample_count),
        .expected     (expected)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic push(input logic [15:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        clear    = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (locked !== 1'b0 || fail !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: locked=%b fail=%b err_pulse=%b, want 0 0 0",
                     locked, fail, err_pulse);
        end
        checks++;
        if (err_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_err_count: got %0d want 0", err_count);
        end
        checks++;
        if (sample_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_sample_count: got %0d want 0", sample_count);
        end
        checks++;
        if (expected !== 16'd0) begin
            errors++;
            $display("FAIL reset_expected: got %0d want 0", expected);
        end
    endtask

    task automatic test_lock();
        do_reset();
        push(16'd1);
        push(16'd39022);
        push(16'd61087);
        push(16'd20196);
        idle();
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: locked=%b want 0", locked);
        end
        push(16'd45005);
        idle();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_locked: locked=%b want 1", locked);
        end
        checks++;
        if (err_count !== 16'd0 || err_pulse !== 1'b0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL lock_errs: err_count=%0d err_pulse=%b fail=%b want 0 0 0",
                     err_count, err_pulse, fail);
        end
        checks++;
        if (sample_count !== 32'd5) begin
            errors++;
            $display("FAIL lock_sample_count: got %0d want 5", sample_count);
        end
        checks++;
        if (expected !== 16'd3882) begin
            errors++;
            $display("FAIL lock_expected: got %0d want 3882", expected);
        end
    endtask

    task automatic test_gap();
        do_reset();
        push(16'd1);
        for (int i = 0; i < 10; i++) idle();
        checks++;
        if (sample_count !== 32'd1 || expected !== 16'd39022) begin
            errors++;
            $display("FAIL gap_hold: sample_count=%0d expected=%0d want 1 39022",
                     sample_count, expected);
        end
        push(16'd39022);
        idle();
        checks++;
        if (sample_count !== 32'd2 || expected !== 16'd61087) begin
            errors++;
            $display("FAIL gap_result: sample_count=%0d expected=%0d want 2 61087",
                     sample_count, expected);
        end
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 16'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL gap_flags: err_pulse=%b err_count=%0d locked=%b want 0 0 0",
                     err_pulse, err_count, locked);
        end
    endtask

`ifndef LCG_CHK_RESYNC_EN
    task automatic test_mismatch();
        do_reset();
        push(16'd1);
        push(16'd39023);
        idle();
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 16'd1 || fail !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL mm_hit: err_pulse=%b err_count=%0d fail=%b locked=%b want 1 1 1 0",
                     err_pulse, err_count, fail, locked);
        end
        idle();
        checks++;
        if (err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL mm_pulse_width: err_pulse=%b want 0", err_pulse);
        end
        push(16'd61087);
        push(16'd7);
        idle();
        checks++;
        if (sample_count !== 32'd4 || err_count !== 16'd1 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL mm_in_fail: sample_count=%0d err_count=%0d err_pulse=%b want 4 1 0",
                     sample_count, err_count, err_pulse);
        end
        checks++;
        if (expected !== 16'd39022 || fail !== 1'b1) begin
            errors++;
            $display("FAIL mm_hold: expected=%0d fail=%b want 39022 1", expected, fail);
        end
        @(negedge clk);
        clear = 1'b1;
        idle();
        checks++;
        if (fail !== 1'b0 || err_count !== 16'd0 || sample_count !== 32'd0 ||
            expected !== 16'd0 || locked !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL mm_clear: fail=%b err_count=%0d sample_count=%0d expected=%0d want 0",
                     fail, err_count, sample_count, expected);
        end
    endtask
`else
    task automatic test_resync();
        do_reset();
        push(16'd1);
        push(16'd39023);
        idle();
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 16'd1 || fail !== 1'b0 ||
            expected !== 16'd20724) begin
            errors++;
            $display("FAIL rs_hit: err_pulse=%b err_count=%0d fail=%b expected=%0d want 1 1 0 20724",
                     err_pulse, err_count, fail, expected);
        end
        push(16'd20724);
        push(16'd32541);
        push(16'd33978);
        push(16'd31707);
        push(16'd11216);
        idle();
        checks++;
        if (locked !== 1'b1 || err_count !== 16'd1 || fail !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL rs_lock: locked=%b err_count=%0d fail=%b err_pulse=%b want 1 1 0 0",
                     locked, err_count, fail, err_pulse);
        end
    endtask
`endif

    task automatic test_clear_priority();
        do_reset();
        push(16'd1);
        push(16'd39022);
        push(16'd61087);
        push(16'd20196);
        push(16'd45005);
        idle();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_prelock: locked=%b want 1", locked);
        end
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd3882;
        idle();
        checks++;
        if (locked !== 1'b0 || sample_count !== 32'd0 || err_pulse !== 1'b0 ||
            expected !== 16'd0) begin
            errors++;
            $display("FAIL clr_same_cycle: locked=%b sample_count=%0d err_pulse=%b expected=%0d",
                     locked, sample_count, err_pulse, expected);
        end
        push(16'd5);
        idle();
        checks++;
        if (sample_count !== 32'd1 || expected !== 16'd8642 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL clr_reseed: sample_count=%0d expected=%0d err_pulse=%b want 1 8642 0",
                     sample_count, expected, err_pulse);
        end
    endtask

    task automatic test_rst_midway();
        do_reset();
        push(16'd1);
        push(16'd39022);
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (locked !== 1'b0 || fail !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0 ||
            sample_count !== 32'd0 || expected !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid: locked=%b fail=%b err_pulse=%b err_count=%0d samples=%0d exp=%0d",
                     locked, fail, err_pulse, err_count, sample_count, expected);
        end
        push(16'd5);
        idle();
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 16'd0 || expected !== 16'd8642 ||
            sample_count !== 32'd1) begin
            errors++;
            $display("FAIL rst_reseed: err_pulse=%b err_count=%0d expected=%0d samples=%0d",
                     err_pulse, err_count, expected, sample_count);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_gap();
`ifndef LCG_CHK_RESYNC_EN
        test_mismatch();
`else
        test_resync();
`endif
        test_clear_priority();
        test_rst_midway();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule

// File: doc/lcg_rng_checker.md
LCG_RNG_CHECKER -- requirements
Module: lcg_rng_checker

Interface
REQ-001 The block SHALL have parameter MULT, default 25173: LCG multiplier.
REQ-002 The block SHALL have parameter INC, default 13849: LCG increment.
REQ-003 The block SHALL have parameter LOCK_COUNT, default 4, range 1..255: consecutive matches required before lock.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid SHALL be an input, 1 bit: in_data holds a sample this cycle.
REQ-007 Port in_data SHALL be an input, 16 bits: sample from the 16-bit LCG generator under check.
REQ-008 Port clear SHALL be an input, 1 bit: synchronous restart of checking, same effect as rst.
REQ-009 Port locked SHALL be an output, 1 bit: LOCK_COUNT consecutive predictions matched.
REQ-010 Port fail SHALL be an output, 1 bit: sticky mismatch state.
REQ-011 Port err_pulse SHALL be an output, 1 bit: one-cycle strobe per mismatch.
REQ-012 Port err_count SHALL be an output, 16 bits: mismatch count, saturating.
REQ-013 Port sample_count SHALL be an output, 32 bits: accepted samples, wrapping.
REQ-014 Port expected SHALL be an output, 16 bits: predicted value of the next sample.

Function
REQ-015 next(x) SHALL equal the low 16 bits of (MULT*x + INC), i.e. arithmetic mod 2^16; the product is computed at full width and truncated.
REQ-016 The FSM SHALL have states IDLE, TRACK and FAIL; state changes only on a cycle with in_valid=1 and clear=0, or on clear/rst.
REQ-017 In IDLE, on in_valid: expected<=next(in_data), match_run<=0, go to TRACK; no comparison is made on this seed sample.
REQ-018 In TRACK, on in_valid with in_data==expected: expected<=next(in_data), match_run<=min(match_run+1, LOCK_COUNT).
REQ-019 locked SHALL be registered and equal (state==TRACK && match_run==LOCK_COUNT); it rises the cycle after the LOCK_COUNT-th matching sample.
REQ-020 In TRACK, on in_valid with in_data!=expected: err_pulse=1 for exactly the next cycle, err_count increments, locked falls the next cycle.
REQ-021 err_count SHALL saturate at 16'hFFFF; further mismatches still pulse err_pulse.
REQ-022 sample_count SHALL increment on every in_valid cycle in any state, except when clear is high; it wraps from 2^32-1 to 0.
REQ-023 In FAIL, samples SHALL be counted but not compared; expected holds; only clear or rst exits FAIL, to IDLE.
REQ-024 fail SHALL equal (state==FAIL), registered.
REQ-025 in_valid=0 cycles SHALL change nothing; gaps between samples of any length are legal.
REQ-026 clear together with in_valid SHALL give priority to clear: the sample is dropped and not counted.
REQ-027 Output latency SHALL be one cycle: every output reflects the sample accepted on the previous edge.

Reset
REQ-028 On rst=1 at a clock edge, state<=IDLE and match_run<=0, and all outputs SHALL be 0: locked, fail, err_pulse, err_count, sample_count, expected.
REQ-029 rst asserted mid-operation, in any state, SHALL abort checking with no err_pulse generated.
REQ-030 clear SHALL perform the identical initialisation; rst has priority over all other inputs.

Configuration
REQ-031 With macro LCG_CHK_RESYNC_EN defined, a mismatch in TRACK SHALL stay in TRACK with expected<=next(in_data) and match_run<=0, so checking resumes from the offending sample; FAIL is unreachable and fail is constant 0.
REQ-032 Without LCG_CHK_RESYNC_EN, a mismatch in TRACK SHALL transition to FAIL per REQ-023.

Verification
REQ-033 Reset, then samples 1, 39022, 61087 and the following 2 correct successors -> locked=1 one cycle after the 5th sample; err_count=0; sample_count=5; expected=next(5th sample).
REQ-034 Macro off: samples 1, 39023 -> err_pulse high for exactly one cycle, err_count=1, fail=1; further samples raise sample_count only; clear -> IDLE with all outputs 0.
REQ-035 Macro on: samples 1, 39023, 20724, then 4 correct successors -> one err_pulse, err_count=1, fail=0, locked=1 after the 4th successor.
REQ-036 Samples 1, 39022 separated by 10 in_valid=0 cycles -> same result as back-to-back samples; sample_count=2.
REQ-037 clear and in_valid high in the same cycle during TRACK with locked=1 -> next cycle state IDLE, sample_count=0, locked=0, no err_pulse.
REQ-038 rst pulsed for 1 cycle during TRACK -> next cycle all outputs 0; the following sample is treated as the seed.
